// File: rtl/accel_frm_rcv.sv
// Accelerometer frame receiver: 8N1 UART byte receiver feeding a frame parser.
// Frame: A5, HI (bits[7:6]=00, carries xmeas[13:8]), LO (xmeas[7:0]).
// Optional macro ACCEL_FRM_CHKSUM_EN appends a CHK byte (HI ^ LO) to each frame.
module accel_frm_rcv #(
  parameter int unsigned BAUD_DIV = 868,
  parameter int unsigned TMO_CYC  = 20 * BAUD_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX_A,
  output logic [13:0] xmeas,
  output logic        accel_vld,
  output logic        frm_err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned CntW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned TmoW = $clog2(TMO_CYC + 1);
  localparam logic [CntW-1:0] HalfM1 = CntW'(BAUD_DIV / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(BAUD_DIV - 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TMO_CYC);
  localparam logic [7:0]      SyncByte = 8'hA5;

  typedef enum logic [1:0] {BIdle, BStart, BData, BStop} bit_st_t;

`ifdef ACCEL_FRM_CHKSUM_EN
  typedef enum logic [1:0] {FHunt, FHi, FLo, FChk} frm_st_t;
`else
  typedef enum logic [1:0] {FHunt, FHi, FLo} frm_st_t;
`endif

  // Synchronizer and edge-detect history
  logic r_rx_meta, r_rx_sync, r_rx_prev;

  // Bit FSM state
  bit_st_t       r_bst;
  logic [CntW-1:0] r_bcnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte;
  logic          r_byte_vld;
  logic          r_stop_err;

  // Frame FSM state
  frm_st_t       r_fst;
  logic [TmoW-1:0] r_tmo;
  logic [5:0]    r_hi;
`ifdef ACCEL_FRM_CHKSUM_EN
  logic [7:0]    r_lo;
`endif
  logic [13:0]   r_xmeas;
  logic          r_accel_vld;
  logic          r_frm_err;
  logic [7:0]    r_err_cnt;

  logic          w_busy;

  assign w_busy = (r_bst != BIdle);

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX_A;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Bit FSM: mid-bit sampling, emits one-cycle byte or stop-error strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bst      <= BIdle;
      r_bcnt     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_byte     <= '0;
      r_byte_vld <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      r_stop_err <= 1'b0;
      case (r_bst)
        BIdle: begin
          r_bcnt    <= '0;
          r_bit_idx <= '0;
          if (r_rx_prev && !r_rx_sync) r_bst <= BStart;
        end
        BStart: begin
          if (r_bcnt == HalfM1) begin
            r_bcnt <= '0;
            // Line back high at mid start bit: glitch, not a byte
            r_bst  <= r_rx_sync ? BIdle : BData;
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        BData: begin
          if (r_bcnt == FullM1) begin
            r_bcnt    <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_bst <= BStop;
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        BStop: begin
          if (r_bcnt == FullM1) begin
            r_bcnt <= '0;
            r_bst  <= BIdle;
            if (r_rx_sync) begin
              r_byte_vld <= 1'b1;
              r_byte     <= r_shift;
            end else begin
              r_stop_err <= 1'b1;
            end
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        default: r_bst <= BIdle;
      endcase
    end
  end

  // Frame FSM: parses bytes, owns xmeas/accel_vld/frm_err and the inter-byte timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fst       <= FHunt;
      r_tmo       <= '0;
      r_hi        <= '0;
`ifdef ACCEL_FRM_CHKSUM_EN
      r_lo        <= '0;
`endif
      r_xmeas     <= '0;
      r_accel_vld <= 1'b0;
      r_frm_err   <= 1'b0;
    end else begin
      r_accel_vld <= 1'b0;
      r_frm_err   <= 1'b0;
      if (r_stop_err) begin
        r_frm_err <= 1'b1;
        r_fst     <= FHunt;
        r_tmo     <= '0;
      end else if (r_byte_vld) begin
        r_tmo <= '0;
        case (r_fst)
          FHunt: begin
            if (r_byte == SyncByte) r_fst <= FHi;
          end
          FHi: begin
            if (r_byte[7:6] == 2'b00) begin
              r_hi  <= r_byte[5:0];
              r_fst <= FLo;
            end else if (r_byte == SyncByte) begin
              // Treat a repeated sync byte as the start of a new frame
              r_frm_err <= 1'b1;
            end else begin
              r_frm_err <= 1'b1;
              r_fst     <= FHunt;
            end
          end
          FLo: begin
`ifdef ACCEL_FRM_CHKSUM_EN
            r_lo  <= r_byte;
            r_fst <= FChk;
`else
            r_xmeas     <= {r_hi, r_byte};
            r_accel_vld <= 1'b1;
            r_fst       <= FHunt;
`endif
          end
`ifdef ACCEL_FRM_CHKSUM_EN
          FChk: begin
            if (r_byte == ({2'b00, r_hi} ^ r_lo)) begin
              r_xmeas     <= {r_hi, r_lo};
              r_accel_vld <= 1'b1;
            end else begin
              r_frm_err <= 1'b1;
            end
            r_fst <= FHunt;
          end
`endif
          default: r_fst <= FHunt;
        endcase
      end else if (r_fst == FHunt || w_busy) begin
        // Gap timer only runs mid-frame while the line is idle
        r_tmo <= '0;
      end else if (r_tmo == TmoMax) begin
        r_frm_err <= 1'b1;
        r_fst     <= FHunt;
        r_tmo     <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

  // Saturating error counter, advanced by each frm_err pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (r_frm_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign xmeas     = r_xmeas;
  assign accel_vld = r_accel_vld;
  assign frm_err   = r_frm_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: doc/accel_frm_rcv.md
ACCEL_FRM_RCV -- requirements
Module: accel_frm_rcv

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 868, clocks per UART bit.
REQ-002 SHALL have parameter TMO_CYC, default 20*BAUD_DIV, maximum idle clocks between bytes of one frame.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port RX_A  input  1  accelerometer UART serial line, idle high, asynchronous to clk.
REQ-006 SHALL have port xmeas  output  14  last valid measurement, two's complement.
REQ-007 SHALL have port accel_vld  output  1  one-cycle pulse marking a new xmeas for the digital core.
REQ-008 SHALL have port frm_err  output  1  one-cycle pulse on any discarded byte or frame.
REQ-009 SHALL have port err_cnt  output  8  saturating count of frm_err pulses.

Function
REQ-010 SHALL pass RX_A through a 2-flop synchronizer before any use; all timing below counts from the synchronized signal.
REQ-011 SHALL run a bit FSM IDLE -> START -> DATA -> STOP -> IDLE, format 8N1, LSB first.
REQ-012 IDLE SHALL leave on a synchronized high-to-low transition; START SHALL sample at BAUD_DIV/2 clocks and return to IDLE without a byte if the line is high.
REQ-013 DATA SHALL sample 8 bits at BAUD_DIV-clock intervals; STOP SHALL sample one bit BAUD_DIV later.
REQ-014 A low stop bit SHALL discard the byte, pulse frm_err, and force the frame FSM to HUNT.
REQ-015 SHALL run a frame FSM HUNT -> HI -> LO [-> CHK] -> HUNT, fed one byte per good stop bit.
REQ-016 HUNT SHALL advance to HI only on byte 0xA5; other bytes are dropped silently.
REQ-017 HI SHALL accept a byte with bits[7:6]=00 as xmeas[13:8]; byte 0xA5 in HI SHALL pulse frm_err and stay in HI (resync); any other byte SHALL pulse frm_err and go to HUNT.
REQ-018 LO SHALL accept any byte as xmeas[7:0].
REQ-019 On frame completion xmeas and accel_vld SHALL update on the same edge, one clock after the final stop-bit sample; xmeas SHALL otherwise hold.
REQ-020 An inter-byte gap exceeding TMO_CYC clocks while in HI, LO or CHK SHALL pulse frm_err and return to HUNT.
REQ-021 err_cnt SHALL increment on each frm_err pulse and hold at 255.
REQ-022 accel_vld and frm_err SHALL never be high in the same cycle.

Reset
REQ-023 rst high at a clock edge SHALL force both FSMs to IDLE/HUNT, xmeas=0, accel_vld=0, frm_err=0, err_cnt=0, synchronizer flops=1.
REQ-024 rst SHALL take priority over every other event, including a frame completing in the same cycle; a frame in progress SHALL be abandoned without frm_err.

Configuration
REQ-025 Macro ACCEL_FRM_CHKSUM_EN defined: after LO the FSM SHALL enter CHK; the byte SHALL equal HI byte XOR LO byte, else frm_err and no update; update timing per REQ-019 relative to the CHK byte.
REQ-026 Macro ACCEL_FRM_CHKSUM_EN undefined: no CHK state exists; frames are 3 bytes.

Verification
REQ-027 Bytes A5,12,34 with BAUD_DIV=16 -> one accel_vld pulse, xmeas=14'h1234, err_cnt=0.
REQ-028 Bytes A5,C0,A5,3F,FF -> frm_err on C0, err_cnt=1, then xmeas=14'h3FFF with accel_vld.
REQ-029 Byte A5 with stop bit held low -> frm_err, err_cnt=1, xmeas unchanged; following A5,00,01 -> xmeas=14'h0001.
REQ-030 A5,05 then line idle TMO_CYC+1 clocks -> frm_err, no accel_vld; 300 such errors -> err_cnt=255.
REQ-031 Glitch low for BAUD_DIV/4 clocks on idle line -> no byte, no pulses.
REQ-032 With ACCEL_FRM_CHKSUM_EN: A5,12,34,26 -> xmeas=14'h1234; A5,12,34,27 -> frm_err, xmeas unchanged; rst mid-frame -> all outputs 0, err_cnt=0.
